scalar_mult_ladder: RTL and testbench
=====================================

# scalar_mult_ladder

Parametrised Montgomery-ladder scalar multiplier controller: computes kP in projective coordinates by sequencing an external point-add unit and an external point-double unit, launching both in parallel on every scalar bit. Successor to the sequential add-then-double ladder controller, with these additions:
- width and scalar length are generic;
- optional leading-zero skipping (variable-time mode) alongside the constant-time mode;
- explicit start/busy/done handshake to the arithmetic units.

The modulus is wired to the add/double units directly; this block never touches field arithmetic.

## Interface
- WIDTH, 256, coordinate width
- KBITS, 256, scalar width (≥2)
- i_clk  in  1  clock, all logic on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_start  in  1  start request, sampled only in IDLE
- i_ct_mode  in  1  1 = constant-time (all KBITS bits), 0 = skip leading zeros; captured with i_start
- i_k  in  KBITS  scalar, captured with i_start
- i_x, i_y, i_z  in  WIDTH each  point P, captured with i_start
- o_busy  out  1  high from the cycle after accepted start through the DONE cycle
- o_done  out  1  one-cycle pulse, result valid
- o_x, o_y, o_z  out  WIDTH each  result kP, held until next o_done
- o_bit_idx  out  $clog2(KBITS)  index of bit being processed
- o_add_start  out  1  add launch pulse
- o_add_x1, o_add_y1, o_add_z1, o_add_x2, o_add_y2, o_add_z2  out  WIDTH each  add operands R0, R1
- i_add_done  in  1  add result pulse
- i_add_x3, i_add_y3, i_add_z3  in  WIDTH each  sum
- o_dbl_start  out  1  double launch pulse
- o_dbl_x1, o_dbl_y1, o_dbl_z1  out  WIDTH each  double operand
- i_dbl_done  in  1  double result pulse
- i_dbl_x3, i_dbl_y3, i_dbl_z3  in  WIDTH each  doubled point

## Operation
- **Reset.** All outputs are 0, FSM is in IDLE, pending flags are cleared. Reset mid-operation abandons the computation; later done pulses from the units are ignored.
- **States.** IDLE, SCAN, LAUNCH, WAIT, UPDATE, DONE.
- **IDLE.**
  - On i_start: R0 := (0,1,0), R1 := (i_x,i_y,i_z), k and mode are latched, idx := KBITS-1.
  - Next state is LAUNCH if ct_mode=1, else SCAN.
  - i_start in any other state is ignored.
- **SCAN.**
  - If k[idx]=1: go to LAUNCH.
  - Else if idx=0: go to DONE with R0 = neutral.
  - Else idx := idx-1 and stay in SCAN.
- **LAUNCH** (one cycle).
  - o_add_start=o_dbl_start=1.
  - Add operands are R0, R1.
  - Double operand is R1 if b=k[idx]=1, else R0.
  - Operand outputs are registered and held stable until the corresponding done pulse.
- **WAIT.**
  - Set add_seen on i_add_done and dbl_seen on i_dbl_done; the two may arrive in the same cycle or in either order.
  - Results are captured on their pulse.
  - When both flags are set, go to UPDATE.
- **UPDATE.**
  - If b=0: R1 := sum, R0 := dbl.
  - If b=1: R0 := sum, R1 := dbl.
  - Clear both flags.
  - If idx=0, go to DONE; else idx := idx-1 and go to LAUNCH.
- **DONE.** o_x/o_y/o_z := R0, o_done=1 for one cycle, then IDLE.
- **Stray pulses.** Done pulses outside WAIT, or a repeated pulse for an already-seen unit, are ignored.
- **Invariant.** R1 − R0 = P after every UPDATE.

## Timing
- Cycle 0: i_start high in IDLE. Cycle 1: o_busy=1, FSM in LAUNCH (ct) or SCAN.
- Let L be the cycles from a start pulse to the later of the two done pulses (L≥1).
- Per bit: L+2 cycles (LAUNCH, L cycles of wait, UPDATE).
- Constant-time mode: o_done in cycle KBITS·(L+2)+1, independent of k.
- Skip mode with z leading zeros (k≠0): SCAN takes z+1 cycles; o_done in cycle z+2+(KBITS−z)·(L+2).
- Skip mode, k=0: o_done in cycle KBITS+1, result (0,1,0), no unit launched.
- o_busy falls in the cycle after DONE; a new i_start is accepted in that cycle.

## Test plan
Bench setup: WIDTH=16, KBITS=8. Bench add model returns the component-wise sum and the double model returns 2× each component; both use fixed latency L=3 unless stated. Under this model, o_x = (k·i_x) mod 2^16.
- **Constant-time, k=0x05.** ct=1, P.x=7 → o_x=35; o_done in cycle 41; exactly 8 add and 8 dbl starts.
- **Skip mode, k=0x05.** ct=0, P.x=7 → o_x=35; o_done in cycle 22; 3 launches; o_bit_idx sequence 7..2 during SCAN, then 2,1,0.
- **Zero and full scalars.**
  - k=0x00, ct=0 → o_done in cycle 9, o_x=0, o_y=1, o_z=0, no launches.
  - k=0xFF, ct=1, P.x=3 → o_x=765.
- **Skewed unit latencies.**
  - Add latency 5, dbl latency 2, k=0xA7, P.x=11, ct=1 → o_x=1837.
  - Repeat with both done pulses in the same cycle → same result.
- **Reset mid-operation.** Assert i_rst during the 3rd WAIT and deassert next cycle → all outputs 0, FSM IDLE. A late i_add_done from the bench model causes no state change. A fresh start with k=0x02, P.x=9 → o_x=18.
- **Ignored inputs.** i_start while busy, and a spurious i_dbl_done in IDLE → no effect on the result or cycle count.

Source files
------------

// File: rtl/scalar_mult_ladder.sv
// Montgomery-ladder scalar multiplier controller. Computes kP by driving an
// external point-add unit and an external point-double unit in parallel, one
// scalar bit per round. Field arithmetic and the modulus live in the units.
//
// state  | meaning
// IDLE   | waiting for i_start
// SCAN   | skip mode: walking down to the most significant set bit of k
// LAUNCH | add/double start pulse, operands already registered
// WAIT   | collecting both unit results in any order
// UPDATE | commit the ladder step into R0/R1, advance the bit index
// DONE   | R0 presented on o_x/o_y/o_z with a one-cycle o_done
module scalar_mult_ladder #(
  parameter int WIDTH = 256,
  parameter int KBITS = 256
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_start,
  input  logic                       i_ct_mode,
  input  logic [KBITS-1:0]           i_k,
  input  logic [WIDTH-1:0]           i_x,
  input  logic [WIDTH-1:0]           i_y,
  input  logic [WIDTH-1:0]           i_z,
  output logic                       o_busy,
  output logic                       o_done,
  output logic [WIDTH-1:0]           o_x,
  output logic [WIDTH-1:0]           o_y,
  output logic [WIDTH-1:0]           o_z,
  output logic [$clog2(KBITS)-1:0]   o_bit_idx,
  output logic                       o_add_start,
  output logic [WIDTH-1:0]           o_add_x1,
  output logic [WIDTH-1:0]           o_add_y1,
  output logic [WIDTH-1:0]           o_add_z1,
  output logic [WIDTH-1:0]           o_add_x2,
  output logic [WIDTH-1:0]           o_add_y2,
  output logic [WIDTH-1:0]           o_add_z2,
  input  logic                       i_add_done,
  input  logic [WIDTH-1:0]           i_add_x3,
  input  logic [WIDTH-1:0]           i_add_y3,
  input  logic [WIDTH-1:0]           i_add_z3,
  output logic                       o_dbl_start,
  output logic [WIDTH-1:0]           o_dbl_x1,
  output logic [WIDTH-1:0]           o_dbl_y1,
  output logic [WIDTH-1:0]           o_dbl_z1,
  input  logic                       i_dbl_done,
  input  logic [WIDTH-1:0]           i_dbl_x3,
  input  logic [WIDTH-1:0]           i_dbl_y3,
  input  logic [WIDTH-1:0]           i_dbl_z3
);

  localparam int IW = $clog2(KBITS);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SCAN   = 3'd1;
  localparam logic [2:0] S_LAUNCH = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_UPDATE = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  typedef struct packed {
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] z;
  } point_t;

  logic [2:0]       state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [KBITS-1:0] k_q, k_d;
  point_t           r0_q, r0_d, r1_q, r1_d;
  point_t           sum_q, dbl_q;
  logic             add_seen_q, dbl_seen_q;
  logic             bit_cur, bit_nxt, add_ok, dbl_ok;

  assign bit_cur   = k_q[idx_q];
  assign bit_nxt   = k_d[idx_d];
  // A result pulse in the current cycle counts as seen so WAIT exits without
  // an extra cycle; the captured copy is ready by UPDATE.
  assign add_ok    = add_seen_q | i_add_done;
  assign dbl_ok    = dbl_seen_q | i_dbl_done;
  assign o_bit_idx = idx_q;

  // Next state, scalar bit index and ladder registers R0/R1
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    k_d     = k_q;
    r0_d    = r0_q;
    r1_d    = r1_q;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          k_d     = i_k;
          idx_d   = IW'(KBITS - 1);
          r0_d    = '0;
          r0_d.y  = WIDTH'(1);
          r1_d    = {i_x, i_y, i_z};
          state_d = i_ct_mode ? S_LAUNCH : S_SCAN;
        end
      end
      S_SCAN: begin
        if (bit_cur)
          state_d = S_LAUNCH;
        else if (idx_q == '0)
          state_d = S_DONE;
        else
          idx_d = idx_q - IW'(1);
      end
      S_LAUNCH: state_d = S_WAIT;
      S_WAIT: begin
        if (add_ok && dbl_ok)
          state_d = S_UPDATE;
      end
      S_UPDATE: begin
        if (bit_cur) begin
          r0_d = sum_q;
          r1_d = dbl_q;
        end else begin
          r0_d = dbl_q;
          r1_d = sum_q;
        end
        if (idx_q == '0) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q - IW'(1);
          state_d = S_LAUNCH;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state, ladder state and registered outputs (loaded from next-state
  // values so operands and results line up with the LAUNCH/DONE cycles)
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      k_q         <= '0;
      r0_q        <= '0;
      r1_q        <= '0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_add_start <= 1'b0;
      o_dbl_start <= 1'b0;
      o_x         <= '0;
      o_y         <= '0;
      o_z         <= '0;
      o_add_x1    <= '0;
      o_add_y1    <= '0;
      o_add_z1    <= '0;
      o_add_x2    <= '0;
      o_add_y2    <= '0;
      o_add_z2    <= '0;
      o_dbl_x1    <= '0;
      o_dbl_y1    <= '0;
      o_dbl_z1    <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      k_q         <= k_d;
      r0_q        <= r0_d;
      r1_q        <= r1_d;
      o_busy      <= (state_d != S_IDLE);
      o_done      <= (state_d == S_DONE);
      o_add_start <= (state_d == S_LAUNCH);
      o_dbl_start <= (state_d == S_LAUNCH);
      if (state_d == S_LAUNCH) begin
        o_add_x1 <= r0_d.x;
        o_add_y1 <= r0_d.y;
        o_add_z1 <= r0_d.z;
        o_add_x2 <= r1_d.x;
        o_add_y2 <= r1_d.y;
        o_add_z2 <= r1_d.z;
        o_dbl_x1 <= bit_nxt ? r1_d.x : r0_d.x;
        o_dbl_y1 <= bit_nxt ? r1_d.y : r0_d.y;
        o_dbl_z1 <= bit_nxt ? r1_d.z : r0_d.z;
      end
      if (state_d == S_DONE) begin
        o_x <= r0_d.x;
        o_y <= r0_d.y;
        o_z <= r0_d.z;
      end
    end
  end

  // Unit result capture: first pulse per unit in WAIT wins, everything else ignored
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      add_seen_q <= 1'b0;
      dbl_seen_q <= 1'b0;
      sum_q      <= '0;
      dbl_q      <= '0;
    end else if (state_q == S_WAIT) begin
      if (i_add_done && !add_seen_q) begin
        add_seen_q <= 1'b1;
        sum_q      <= {i_add_x3, i_add_y3, i_add_z3};
      end
      if (i_dbl_done && !dbl_seen_q) begin
        dbl_seen_q <= 1'b1;
        dbl_q      <= {i_dbl_x3, i_dbl_y3, i_dbl_z3};
      end
    end else if (state_q == S_UPDATE) begin
      add_seen_q <= 1'b0;
      dbl_seen_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_scalar_mult_ladder.sv
`timescale 1ns/1ps
module tb_scalar_mult_ladder;

  localparam int W  = 16;
  localparam int KB = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          ct_mode = 1'b0;
  logic [KB-1:0] k_in = '0;
  logic [W-1:0]  px = '0, py = '0, pz = '0;
  logic          busy, done;
  logic [W-1:0]  rx, ry, rz;
  logic [2:0]    bit_idx;
  logic          add_start, dbl_start;
  logic [W-1:0]  ax1, ay1, az1, ax2, ay2, az2;
  logic [W-1:0]  dx1, dy1, dz1;
  logic          add_done_m = 1'b0, dbl_done_m = 1'b0, dbl_spur = 1'b0;
  logic [W-1:0]  ax3 = '0, ay3 = '0, az3 = '0;
  logic [W-1:0]  dx3 = '0, dy3 = '0, dz3 = '0;

  int add_lat = 3;
  int dbl_lat = 3;
  int cyc = 0;
  int total = 0;
  int bad = 0;

  typedef struct {
    int x;
    int y;
    int z;
    int cyc;
    int launch;
  } exp_t;
  exp_t exp_q[$];

  scalar_mult_ladder #(.WIDTH(W), .KBITS(KB)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_ct_mode(ct_mode), .i_k(k_in),
    .i_x(px), .i_y(py), .i_z(pz),
    .o_busy(busy), .o_done(done), .o_x(rx), .o_y(ry), .o_z(rz), .o_bit_idx(bit_idx),
    .o_add_start(add_start),
    .o_add_x1(ax1), .o_add_y1(ay1), .o_add_z1(az1),
    .o_add_x2(ax2), .o_add_y2(ay2), .o_add_z2(az2),
    .i_add_done(add_done_m), .i_add_x3(ax3), .i_add_y3(ay3), .i_add_z3(az3),
    .o_dbl_start(dbl_start), .o_dbl_x1(dx1), .o_dbl_y1(dy1), .o_dbl_z1(dz1),
    .i_dbl_done(dbl_done_m | dbl_spur), .i_dbl_x3(dx3), .i_dbl_y3(dy3), .i_dbl_z3(dz3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  // R0 ends at 2^n*R0init + k*(P - R0init) under the linear unit models,
  // n being the number of scalar bits the ladder processed.
  function automatic int exp_y(input logic [7:0] k, input logic ct, input logic [15:0] y);
    int n;
    n = 8;
    if (!ct) begin
      n = 0;
      for (int i = 7; i >= 0; i--)
        if (k[i]) begin
          n = i + 1;
          break;
        end
    end
    return ((1 << n) + int'(k) * (int'(y) - 1)) & 32'hFFFF;
  endfunction

  // add unit model: component-wise sum after add_lat cycles
  initial begin : add_model
    int cnt;
    logic [W-1:0] sx, sy, sz;
    cnt = 0;
    forever begin
      @(negedge clk);
      add_done_m = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          add_done_m = 1'b1;
          ax3 = sx; ay3 = sy; az3 = sz;
        end
      end
      if (add_start) begin
        cnt = add_lat;
        sx = ax1 + ax2; sy = ay1 + ay2; sz = az1 + az2;
      end
    end
  end

  // double unit model: 2x each component after dbl_lat cycles
  initial begin : dbl_model
    int cnt;
    logic [W-1:0] sx, sy, sz;
    cnt = 0;
    forever begin
      @(negedge clk);
      dbl_done_m = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          dbl_done_m = 1'b1;
          dx3 = sx; dy3 = sy; dz3 = sz;
        end
      end
      if (dbl_start) begin
        cnt = dbl_lat;
        sx = dx1 + dx1; sy = dy1 + dy1; sz = dz1 + dz1;
      end
    end
  end

  // scoreboard monitor: pops an expectation on every o_done
  initial begin : monitor
    logic busy_prev;
    int start_cyc, n_add, n_dbl;
    exp_t e;
    busy_prev = 1'b0;
    start_cyc = 0; n_add = 0; n_dbl = 0;
    forever begin
      @(negedge clk);
      if (busy && !busy_prev) begin
        start_cyc = cyc - 1;
        n_add = 0;
        n_dbl = 0;
      end
      if (add_start) n_add++;
      if (dbl_start) n_dbl++;
      if (done) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_done got=done want=none");
        end else begin
          e = exp_q.pop_front();
          chk("res_x", int'(rx), e.x);
          chk("res_y", int'(ry), e.y);
          chk("res_z", int'(rz), e.z);
          chk("done_cycle", cyc - start_cyc, e.cyc);
          chk("add_launches", n_add, e.launch);
          chk("dbl_launches", n_dbl, e.launch);
        end
      end
      busy_prev = busy;
    end
  end

  task automatic start_op(input logic [7:0] k, input logic ct, input logic [15:0] x,
                          input logic [15:0] y, input logic [15:0] z, input int ex,
                          input int ecyc, input int elaunch, input bit push);
    exp_t e;
    if (push) begin
      e.x = ex;
      e.y = exp_y(k, ct, y);
      e.z = (int'(k) * int'(z)) & 32'hFFFF;
      e.cyc = ecyc;
      e.launch = elaunch;
      exp_q.push_back(e);
    end
    k_in = k; ct_mode = ct; px = x; py = y; pz = z;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      total++; bad++;
      $display("FAIL %s_timeout got=no_done want=done", name);
    end
    @(negedge clk);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog got=hang want=finish");
    $fatal(1);
  end

  initial begin : stimulus
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_x", int'(rx), 0);
    chk("rst_y", int'(ry), 0);
    chk("rst_add_start", int'(add_start), 0);
    rst = 1'b0;
    @(negedge clk);

    // constant time, k=0x05
    start_op(8'h05, 1'b1, 16'd7, 16'd2, 16'd3, 35, 41, 8, 1'b1);
    wait_done("ct_05");

    // skip mode, k=0x05, with bit index trace
    start_op(8'h05, 1'b0, 16'd7, 16'd2, 16'd3, 35, 22, 3, 1'b1);
    for (int c = 1; c <= 6; c++) begin
      chk("scan_idx", int'(bit_idx), 8 - c);
      @(negedge clk);
    end
    begin
      int want, n;
      want = 2; n = 0;
      while (done !== 1'b1 && n < 100) begin
        if (add_start) begin
          chk("launch_idx", int'(bit_idx), want);
          want--;
        end
        @(negedge clk);
        n++;
      end
      chk("launch_idx_all", want, -1);
    end
    wait_done("skip_05");

    // zero and full scalars
    start_op(8'h00, 1'b0, 16'd7, 16'd2, 16'd3, 0, 9, 0, 1'b1);
    wait_done("skip_00");
    start_op(8'hFF, 1'b1, 16'd3, 16'd5, 16'd4, 765, 41, 8, 1'b1);
    wait_done("ct_ff");

    // skewed latencies, then coincident done pulses
    add_lat = 5; dbl_lat = 2;
    start_op(8'hA7, 1'b1, 16'd11, 16'd6, 16'd1, 1837, 57, 8, 1'b1);
    wait_done("skew");
    add_lat = 4; dbl_lat = 4;
    start_op(8'hA7, 1'b1, 16'd11, 16'd6, 16'd1, 1837, 49, 8, 1'b1);
    wait_done("same_cycle");
    add_lat = 3; dbl_lat = 3;

    // reset during the third WAIT
    start_op(8'hF3, 1'b1, 16'd5, 16'd5, 16'd5, 0, 0, 0, 1'b0);
    begin
      int seen, n, stray, late;
      seen = 0; n = 0;
      while (n < 100) begin
        if (add_start) begin
          seen++;
          if (seen == 3) break;
        end
        @(negedge clk);
        n++;
      end
      chk("rst_third_launch", seen, 3);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_rst_busy", int'(busy), 0);
      chk("mid_rst_done", int'(done), 0);
      chk("mid_rst_x", int'(rx), 0);
      chk("mid_rst_y", int'(ry), 0);
      chk("mid_rst_z", int'(rz), 0);
      chk("mid_rst_add_start", int'(add_start), 0);
      chk("mid_rst_bit_idx", int'(bit_idx), 0);
      chk("mid_rst_add_y1", int'(ay1), 0);
      chk("mid_rst_dbl_y1", int'(dy1), 0);
      stray = 0; late = 0;
      repeat (6) begin
        @(negedge clk);
        if (add_done_m) late++;
        if (busy || done || bit_idx != 3'd0) stray++;
      end
      chk("late_pulse_seen", late, 1);
      chk("late_pulse_ignored", stray, 0);
    end
    start_op(8'h02, 1'b1, 16'd9, 16'd1, 16'd2, 18, 41, 8, 1'b1);
    wait_done("after_rst");

    // stray double done in IDLE, start while busy
    dbl_spur = 1'b1;
    @(negedge clk);
    dbl_spur = 1'b0;
    start_op(8'h05, 1'b0, 16'd7, 16'd2, 16'd3, 35, 22, 3, 1'b1);
    @(negedge clk);
    k_in = 8'hFF; ct_mode = 1'b1; px = 16'd100;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("ignored");

    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
